// File: rtl/measure_seq.sv
// Measurement sequencer: arms on command, waits for the opening probe edge, then drives an
// external counter with prescaled ticks until the closing edge, timeout or saturation.
module measure_seq #(
    parameter int WIDTH = 16,
    parameter int PSW   = 8
) (
    input  logic             clk,
    input  logic             sysrst,
    input  logic             cmd_arm,
    input  logic             cmd_abort,
    input  logic [1:0]       mode,
    input  logic             probe,
    input  logic [PSW-1:0]   prescale,
    input  logic [WIDTH-1:0] timeout,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_start,
    output logic             cnt_stop,
    output logic             cnt_reset,
    output logic             cnt_count,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             timed_out,
    output logic             overflow
);
    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_OPEN, MEASURE, CAPTURE} state_t;

    localparam logic [PSW-1:0] PS_ONE  = PSW'(1);
    localparam logic [WIDTH:0] CNT_MAX = {1'b0, {WIDTH{1'b1}}};

    state_t           state;
    logic [2:0]       sync_pipe;
    logic [1:0]       mode_l;
    logic [PSW-1:0]   prescale_l;
    logic [PSW-1:0]   pcnt;
    logic [WIDTH-1:0] timeout_l;

    logic             rise, fall, open_edge, close_edge, tick_due, hit_timeout, hit_max;
    logic [WIDTH:0]   projected;

    always_comb begin
        rise       = sync_pipe[1] & ~sync_pipe[2];
        fall       = ~sync_pipe[1] & sync_pipe[2];
        open_edge  = (mode_l == 2'd1) ? fall : rise;
        close_edge = (mode_l == 2'd0) ? fall : rise;
        tick_due   = (pcnt == '0);
        // A tick issued last cycle has not reached cnt_value yet; account for it so the
        // counter stops exactly at the limit instead of one past it.
        projected   = {1'b0, cnt_value} + {{WIDTH{1'b0}}, cnt_count};
        hit_timeout = (timeout_l != '0) && (projected >= {1'b0, timeout_l});
        hit_max     = (projected >= CNT_MAX);
    end

    always_ff @(posedge clk or posedge sysrst) begin
        if (sysrst) begin
            state      <= IDLE;
            sync_pipe  <= '0;
            mode_l     <= '0;
            prescale_l <= '0;
            pcnt       <= '0;
            timeout_l  <= '0;
            cnt_start  <= 1'b0;
            cnt_stop   <= 1'b0;
            cnt_reset  <= 1'b0;
            cnt_count  <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            timed_out  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], probe};
            cnt_start <= 1'b0;
            cnt_stop  <= 1'b0;
            cnt_reset <= 1'b0;
            cnt_count <= 1'b0;
            done      <= 1'b0;

            if (state != IDLE && cmd_abort) begin
                cnt_stop <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: if (cmd_arm) begin
                        mode_l     <= mode;
                        prescale_l <= prescale;
                        timeout_l  <= timeout;
                        timed_out  <= 1'b0;
                        overflow   <= 1'b0;
                        cnt_reset  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= CLEAR;
                    end
                    CLEAR: state <= WAIT_OPEN;
                    WAIT_OPEN: if (open_edge) begin
                        cnt_start <= 1'b1;
                        pcnt      <= prescale_l;
                        state     <= MEASURE;
                    end
                    MEASURE: begin
                        if (close_edge) begin
                            cnt_stop <= 1'b1;
                            state    <= CAPTURE;
                        end else if (hit_timeout) begin
                            cnt_stop  <= 1'b1;
                            timed_out <= 1'b1;
                            state     <= CAPTURE;
                        end else if (tick_due && hit_max) begin
                            cnt_stop <= 1'b1;
                            overflow <= 1'b1;
                            state    <= CAPTURE;
                        end else if (tick_due) begin
                            cnt_count <= 1'b1;
                            pcnt      <= prescale_l;
                        end else begin
                            pcnt <= pcnt - PS_ONE;
                        end
                    end
                    CAPTURE: begin
                        result <= cnt_value;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_measure_seq.sv
// Directed bench for measure_seq: vector table of probe waveforms plus hand-written abort,
// arm-while-busy and async reset sequences; a behavioural counter closes the loop.
module tb_measure_seq;
    logic        clk = 1'b0;
    logic        sysrst;
    logic        cmd_arm, cmd_abort, probe;
    logic [1:0]  mode;
    logic [7:0]  prescale;
    logic [15:0] timeout, cnt_value, result;
    logic        cnt_start, cnt_stop, cnt_reset, cnt_count, done, busy, timed_out, overflow;

    logic        arm_b, abort_b, probe_b;
    logic [1:0]  mode_b;
    logic [7:0]  prescale_b;
    logic [3:0]  timeout_b, cnt_value_b, result_b;
    logic        start_b, stop_b, reset_b, count_b, done_b, busy_b, to_b, ov_b;

    always #5 clk = ~clk;

    measure_seq #(.WIDTH(16), .PSW(8)) dut (
        .clk(clk), .sysrst(sysrst), .cmd_arm(cmd_arm), .cmd_abort(cmd_abort), .mode(mode),
        .probe(probe), .prescale(prescale), .timeout(timeout), .cnt_value(cnt_value),
        .cnt_start(cnt_start), .cnt_stop(cnt_stop), .cnt_reset(cnt_reset), .cnt_count(cnt_count),
        .result(result), .done(done), .busy(busy), .timed_out(timed_out), .overflow(overflow));

    measure_seq #(.WIDTH(4), .PSW(8)) dut_b (
        .clk(clk), .sysrst(sysrst), .cmd_arm(arm_b), .cmd_abort(abort_b), .mode(mode_b),
        .probe(probe_b), .prescale(prescale_b), .timeout(timeout_b), .cnt_value(cnt_value_b),
        .cnt_start(start_b), .cnt_stop(stop_b), .cnt_reset(reset_b), .cnt_count(count_b),
        .result(result_b), .done(done_b), .busy(busy_b), .timed_out(to_b), .overflow(ov_b));

    // Behavioural counters: start/stop set/clear run, count increments while running (wraps freely).
    logic run_a, run_b;
    always @(posedge clk or posedge sysrst) begin
        if (sysrst) begin
            run_a <= 1'b0; cnt_value <= '0;
        end else if (cnt_reset) begin
            run_a <= 1'b0; cnt_value <= '0;
        end else begin
            if (cnt_start) run_a <= 1'b1;
            if (cnt_stop)  run_a <= 1'b0;
            if (cnt_count && run_a) cnt_value <= cnt_value + 16'd1;
        end
    end
    always @(posedge clk or posedge sysrst) begin
        if (sysrst) begin
            run_b <= 1'b0; cnt_value_b <= '0;
        end else if (reset_b) begin
            run_b <= 1'b0; cnt_value_b <= '0;
        end else begin
            if (start_b) run_b <= 1'b1;
            if (stop_b)  run_b <= 1'b0;
            if (count_b && run_b) cnt_value_b <= cnt_value_b + 4'd1;
        end
    end

    int cyc = 0;
    int n_start = 0, n_stop = 0, n_reset = 0, n_done = 0, n_done_b = 0;
    int start_cyc = 0, stop_cyc = 0, last_tick = -1, exp_gap = 0;
    int clash = 0, stray = 0, gap_err = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (cnt_start) begin n_start++; start_cyc = cyc; last_tick = -1; end
        if (cnt_stop)  begin n_stop++;  stop_cyc = cyc; end
        if (cnt_reset) n_reset++;
        if (done)      n_done++;
        if (done_b)    n_done_b++;
        if ((cnt_start && cnt_stop) || (cnt_reset && cnt_start)) clash++;
        if (cnt_count && !busy) stray++;
        if (cnt_count) begin
            if (last_tick >= 0 && exp_gap != 0 && (cyc - last_tick) != exp_gap) gap_err++;
            last_tick = cyc;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  ps;
        logic [15:0] to;
        logic        init;
        int          d1, d2;
        int          lo, hi;
        logic        exp_to, exp_ov;
        int          span;
    } vec_t;
    vec_t vecs[7];

    task automatic run_vec(input int idx, input vec_t v);
        int d0;
        probe = v.init;
        repeat (6) step();
        mode = v.mode; prescale = v.ps; timeout = v.to; exp_gap = int'(v.ps) + 1;
        d0 = n_done;
        cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
        repeat (4) step();
        probe = ~probe;
        repeat (v.d1) step();
        probe = ~probe;
        if (v.d2 != 0) begin
            repeat (v.d2) step();
            probe = ~probe;
        end
        for (int k = 0; k < 400 && n_done == d0; k++) step();
        step();
        chk_rng($sformatf("v%0d result", idx), int'(result), v.lo, v.hi);
        chk($sformatf("v%0d timed_out", idx), int'(timed_out), int'(v.exp_to));
        chk($sformatf("v%0d overflow", idx), int'(overflow), int'(v.exp_ov));
        chk($sformatf("v%0d done pulses", idx), n_done - d0, 1);
        chk($sformatf("v%0d busy after", idx), int'(busy), 0);
        if (v.span != 0) chk($sformatf("v%0d start-stop span", idx), stop_cyc - start_cyc, v.span);
    endtask

    initial begin
        vecs[0] = '{2'd0, 8'd0, 16'd0,  1'b0, 100, 0,  99, 101, 1'b0, 1'b0, 100};
        vecs[1] = '{2'd2, 8'd3, 16'd0,  1'b0, 20,  20, 9,  11,  1'b0, 1'b0, 40};
        vecs[2] = '{2'd1, 8'd0, 16'd25, 1'b1, 200, 0,  25, 25,  1'b1, 1'b0, 0};
        vecs[3] = '{2'd0, 8'd1, 16'd0,  1'b0, 60,  0,  29, 31,  1'b0, 1'b0, 60};
        vecs[4] = '{2'd3, 8'd0, 16'd0,  1'b0, 10,  15, 24, 26,  1'b0, 1'b0, 25};
        vecs[5] = '{2'd0, 8'd0, 16'd50, 1'b0, 30,  0,  29, 31,  1'b0, 1'b0, 30};
        vecs[6] = '{2'd0, 8'd0, 16'd1,  1'b0, 50,  0,  1,  1,   1'b1, 1'b0, 0};

        sysrst = 1'b1; cmd_arm = 0; cmd_abort = 0; probe = 0; mode = 0; prescale = 0; timeout = 0;
        arm_b = 0; abort_b = 0; probe_b = 0; mode_b = 0; prescale_b = 0; timeout_b = 0;
        repeat (3) step();
        chk("reset outputs", int'({cnt_start, cnt_stop, cnt_reset, cnt_count, done, busy, timed_out, overflow}), 0);
        chk("reset result", int'(result), 0);
        @(negedge clk); sysrst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Saturation on the 4-bit instance: long high pulse must stop at 15 without wrapping.
        probe_b = 1'b0; repeat (6) step();
        arm_b = 1'b1; step(); arm_b = 1'b0;
        repeat (4) step();
        probe_b = 1'b1;
        for (int k = 0; k < 100 && n_done_b == 0; k++) step();
        step();
        chk("sat result", int'(result_b), 15);
        chk("sat overflow", int'(ov_b), 1);
        chk("sat timed_out", int'(to_b), 0);
        chk("sat counter no wrap", int'(cnt_value_b), 15);
        chk("sat done pulses", n_done_b, 1);
        probe_b = 1'b0;

        // Abort in WAIT_OPEN: last result was 1 and must survive.
        probe = 1'b0; repeat (6) step();
        mode = 2'd0; prescale = 8'd0; timeout = 16'd0;
        cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
        repeat (4) step();
        begin
            int s0, d0;
            s0 = n_stop; d0 = n_done;
            chk("wait_open busy", int'(busy), 1);
            cmd_abort = 1'b1; step(); cmd_abort = 1'b0;
            chk("abort1 busy drop", int'(busy), 0);
            step();
            chk("abort1 stop pulse", n_stop - s0, 1);
            chk("abort1 no done", n_done - d0, 0);
            chk("abort1 result held", int'(result), 1);
        end

        // Abort in MEASURE, with an ignored second arm first.
        cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
        repeat (4) step();
        probe = 1'b1;
        repeat (20) step();
        begin
            int r0, d0;
            r0 = n_reset; d0 = n_done;
            cmd_arm = 1'b1; mode = 2'd1; step(); cmd_arm = 1'b0;
            step();
            chk("rearm ignored busy", int'(busy), 1);
            chk("rearm no counter reset", n_reset - r0, 0);
            chk("rearm counting on", int'(run_a), 1);
            cmd_abort = 1'b1; step(); cmd_abort = 1'b0;
            chk("abort2 busy drop", int'(busy), 0);
            repeat (3) step();
            chk("abort2 no done", n_done - d0, 0);
            chk("abort2 result held", int'(result), 1);
            chk("abort2 timed_out", int'(timed_out), 0);
            chk("abort2 counter halted", int'(run_a), 0);
        end

        // Arm and abort together in IDLE: arm wins.
        begin
            int r0;
            r0 = n_reset;
            cmd_arm = 1'b1; cmd_abort = 1'b1; step(); cmd_arm = 1'b0; cmd_abort = 1'b0;
            chk("arm beats abort busy", int'(busy), 1);
            step();
            chk("arm beats abort reset", n_reset - r0, 1);
            cmd_abort = 1'b1; step(); cmd_abort = 1'b0;
            chk("cleanup abort", int'(busy), 0);
        end

        // Async reset mid-MEASURE, then a clean measurement.
        probe = 1'b0; repeat (6) step();
        mode = 2'd0; prescale = 8'd0; timeout = 16'd0;
        cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
        repeat (4) step();
        probe = 1'b1;
        repeat (10) step();
        chk("pre-reset busy", int'(busy), 1);
        #2 sysrst = 1'b1;
        #1;
        chk("async reset outputs", int'({cnt_start, cnt_stop, cnt_reset, cnt_count, done, busy, timed_out, overflow}), 0);
        chk("async reset result", int'(result), 0);
        @(negedge clk); sysrst = 1'b0;
        step();
        run_vec(7, '{2'd0, 8'd0, 16'd0, 1'b0, 40, 0, 39, 41, 1'b0, 1'b0, 40});

        chk("start/stop/reset clash", clash, 0);
        chk("tick outside measure", stray, 0);
        chk("tick spacing", gap_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/measure_seq.md
Name: measure_seq

Overview:
- Sequencer that drives one `counter` instance to measure a timing property of an external probe signal: high-pulse width, low-pulse width, or full period.
- Arms on command and waits for the qualifying probe edge. It then starts the counter, feeds it prescaled count ticks, stops it on the closing edge, timeout or saturation, and latches the result.
- Sits between the host command/register interface and the counter datapath.

Parameters:
- WIDTH, 16, counter/result/timeout width; must match the attached counter.
- PSW, 8, prescaler reload width.

Ports:
- clk  in  1  system clock
- sysrst  in  1  reset, asynchronous, active-high
- cmd_arm  in  1  one-cycle pulse: begin a measurement (ignored unless idle)
- cmd_abort  in  1  one-cycle pulse: cancel the measurement, return to idle
- mode  in  2  0=high width, 1=low width, 2=period (rise to rise), 3=reserved (behaves as 2); sampled on accepted arm
- probe  in  1  asynchronous measured signal
- prescale  in  PSW  a tick every prescale+1 clk cycles; sampled on accepted arm
- timeout  in  WIDTH  0=disabled, else stop when count reaches this value; sampled on accepted arm
- cnt_value  in  WIDTH  counter value
- cnt_start  out  1  to counter start
- cnt_stop  out  1  to counter stop
- cnt_reset  out  1  to counter reset
- cnt_count  out  1  to counter count (prescaler tick)
- result  out  WIDTH  last captured count
- done  out  1  one-cycle pulse when result is valid
- busy  out  1  high in every state except IDLE
- timed_out  out  1  sticky status for the last measurement
- overflow  out  1  sticky status for the last measurement

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; result=0; prescaler=0; synchroniser=0.
- All outputs are registered.
- Probe path: 2-flop synchroniser, then a third flop for edges.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Total latency from a probe change to an edge strobe: 3 clk.
- Opening edge: rise for modes 0/2, fall for mode 1.
- Closing edge: fall for mode 0, rise for mode 1, rise for mode 2.
- States: IDLE, CLEAR, WAIT_OPEN, MEASURE, CAPTURE.
- IDLE:
  - On cmd_arm: latch mode/prescale/timeout, clear timed_out and overflow, pulse cnt_reset for one cycle, go to CLEAR.
- CLEAR:
  - One cycle, lets the counter reset land. Go to WAIT_OPEN.
  - Edges seen in CLEAR are ignored.
- WAIT_OPEN:
  - On the opening edge: pulse cnt_start, load the prescaler with prescale, go to MEASURE.
  - No timeout applies here; waiting is unbounded until abort.
- MEASURE:
  - Prescaler decrements each clk. At 0 it reloads and cnt_count pulses for one cycle.
  - prescale=0 gives cnt_count high on every MEASURE cycle.
  - Closing edge: pulse cnt_stop, go to CAPTURE.
  - Else if timeout!=0 and cnt_value>=timeout: pulse cnt_stop, set timed_out, go to CAPTURE.
  - Else if cnt_value is all-ones and a tick is due: suppress that tick, pulse cnt_stop, set overflow, go to CAPTURE. The counter never wraps.
  - Priority, highest first: abort, closing edge, timeout, overflow.
- CAPTURE:
  - Waits one cycle for the counter to settle. Then result<=cnt_value, done pulses, go to IDLE.
  - cmd_arm is accepted again the cycle after done.
- cmd_abort:
  - In any non-IDLE state: pulse cnt_stop, go to IDLE.
  - result is unchanged and done does not pulse; timed_out/overflow are unchanged.
  - If cmd_abort and cmd_arm coincide in IDLE, arm wins.
- cmd_arm while busy is ignored, with no side effects.
- Count granularity: result is the number of ticks (±1 tick quantisation), not clk cycles. Edge latency is equal on open and close, so it cancels.
- Mode 2 counts from rise to the next rise; the intervening fall is ignored.
- Never assert cnt_start and cnt_stop in the same cycle (the counter would toggle).
- cnt_reset and cnt_start are never asserted in the same cycle.
- sysrst asserted mid-measurement: immediate IDLE. The counter gets its own reset from sysrst.

Test Plan:
- Mode 0, prescale=0, timeout=0; arm, probe rises, held high 100 clk, then falls -> cnt_start then cnt_stop exactly 100 clk apart; result=100 (±1); done one cycle; timed_out=0.
- Mode 2, prescale=3; 40-clk period square wave -> result=10 (±1); cnt_count every 4th clk while in MEASURE only.
- Mode 1, timeout=25, prescale=0; probe falls and stays low -> stop at count 25; timed_out=1; result=25; done pulses.
- WIDTH=4, prescale=0, timeout=0; long high pulse -> stop at 15, overflow=1, result=15, no wrap to 0.
- Abort in WAIT_OPEN, then abort in MEASURE -> busy drops next cycle; no done; result holds the previous value; a second cmd_arm during MEASURE is ignored.
- sysrst pulse mid-MEASURE (async, between clk edges) -> outputs 0 immediately; after release a fresh arm and measurement works normally.
